// File: rtl/gps_ca_codegen.sv
`default_nettype none
// ============================================================================
// Module      : gps_ca_codegen
// Description : GPS L1 C/A Gold-code generator. Runs on gps_clk_fast and
//               emits one chip every CHIP_DIV clock cycles, giving the
//               1023-chip PRN sequence for SV 1..32. A 1 ms epoch strobe
//               marks chip 0 of every period.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : CHIP_DIV    gps_clk_fast cycles per chip (>= 2)
// Ports       : gps_clk_fast  in   clock, all logic on rising edge
//               gps_rst       in   synchronous active-high reset
//               sv_num[5:0]   in   PRN select 1..32, sampled on start
//               start         in   load PRN and begin at chip 0
//               stop          in   halt and return to idle
//               busy          out  high while generating
//               ca_code       out  current chip, held between strobes
//               chip_valid    out  strobe: new ca_code/chip_idx presented
//               chip_idx[9:0] out  index of presented chip 0..1022
//               epoch         out  strobe with chip_valid when chip_idx==0
//               prn_err       out  pulse: start with sv_num outside 1..32
//               epoch_cnt[4:0]out  ms epoch count 0..19  (option only)
//               bit_edge      out  20 ms nav-bit boundary (option only)
// Options     : define GPS_CA_EPOCH_CNT_EN to add epoch_cnt / bit_edge.
// ============================================================================
module gps_ca_codegen #(
    parameter int CHIP_DIV = 10
) (
    input  logic       gps_clk_fast,
    input  logic       gps_rst,
    input  logic [5:0] sv_num,
    input  logic       start,
    input  logic       stop,
    output logic       busy,
    output logic       ca_code,
    output logic       chip_valid,
    output logic [9:0] chip_idx,
    output logic       epoch,
    output logic       prn_err
`ifdef GPS_CA_EPOCH_CNT_EN
    ,
    output logic [4:0] epoch_cnt,
    output logic       bit_edge
`endif
);

    localparam int          c_DIV_W  = (CHIP_DIV > 2) ? $clog2(CHIP_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CHIP_DIV - 1);
    localparam logic [10:1] c_ONES   = 10'h3FF;
    // Both registers step from all-ones to the same value (each feedback
    // sum of all-ones taps is even), so chip 0 needs no live LFSR state.
    localparam logic [10:1] c_STEP1  = 10'h3FE;
    localparam logic [9:0]  c_LAST_CHIP = 10'd1022;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [10:1]         r_g1;
    logic [10:1]         r_g2;
    logic [3:0]          r_tap_a;
    logic [3:0]          r_tap_b;
    logic [c_DIV_W-1:0]  r_div;

    logic                w_sv_ok;
    logic                w_load;
    logic [7:0]          w_taps;
    logic                w_chip;
    logic [10:1]         w_g1_next;
    logic [10:1]         w_g2_next;

    // G2 phase-select tap pairs (a,b) for PRN 1..32.
    function automatic logic [7:0] tap_pair(input logic [5:0] prn);
        case (prn)
            6'd1:    tap_pair = {4'd2, 4'd6};
            6'd2:    tap_pair = {4'd3, 4'd7};
            6'd3:    tap_pair = {4'd4, 4'd8};
            6'd4:    tap_pair = {4'd5, 4'd9};
            6'd5:    tap_pair = {4'd1, 4'd9};
            6'd6:    tap_pair = {4'd2, 4'd10};
            6'd7:    tap_pair = {4'd1, 4'd8};
            6'd8:    tap_pair = {4'd2, 4'd9};
            6'd9:    tap_pair = {4'd3, 4'd10};
            6'd10:   tap_pair = {4'd2, 4'd3};
            6'd11:   tap_pair = {4'd3, 4'd4};
            6'd12:   tap_pair = {4'd5, 4'd6};
            6'd13:   tap_pair = {4'd6, 4'd7};
            6'd14:   tap_pair = {4'd7, 4'd8};
            6'd15:   tap_pair = {4'd8, 4'd9};
            6'd16:   tap_pair = {4'd9, 4'd10};
            6'd17:   tap_pair = {4'd1, 4'd4};
            6'd18:   tap_pair = {4'd2, 4'd5};
            6'd19:   tap_pair = {4'd3, 4'd6};
            6'd20:   tap_pair = {4'd4, 4'd7};
            6'd21:   tap_pair = {4'd5, 4'd8};
            6'd22:   tap_pair = {4'd6, 4'd9};
            6'd23:   tap_pair = {4'd1, 4'd3};
            6'd24:   tap_pair = {4'd4, 4'd6};
            6'd25:   tap_pair = {4'd5, 4'd7};
            6'd26:   tap_pair = {4'd6, 4'd8};
            6'd27:   tap_pair = {4'd7, 4'd9};
            6'd28:   tap_pair = {4'd8, 4'd10};
            6'd29:   tap_pair = {4'd1, 4'd6};
            6'd30:   tap_pair = {4'd2, 4'd7};
            6'd31:   tap_pair = {4'd3, 4'd8};
            6'd32:   tap_pair = {4'd4, 4'd9};
            default: tap_pair = {4'd2, 4'd6};   // never latched: load is gated by w_sv_ok
        endcase
    endfunction

    assign w_sv_ok = (sv_num != 6'd0) && (sv_num <= 6'd32);
    // stop outranks start in every state
    assign w_load  = start && !stop && w_sv_ok;
    assign w_taps  = tap_pair(sv_num);

    assign w_chip    = r_g1[10] ^ r_g2[r_tap_a] ^ r_g2[r_tap_b];
    assign w_g1_next = {r_g1[9:1], r_g1[3] ^ r_g1[10]};
    assign w_g2_next = {r_g2[9:1], r_g2[2] ^ r_g2[3] ^ r_g2[6] ^ r_g2[8] ^ r_g2[9] ^ r_g2[10]};

    assign busy = (r_state == S_RUN);

    always_ff @(posedge gps_clk_fast) begin
        if (gps_rst) begin
            r_state    <= S_IDLE;
            r_g1       <= c_ONES;
            r_g2       <= c_ONES;
            r_tap_a    <= 4'd2;
            r_tap_b    <= 4'd6;
            r_div      <= '0;
            ca_code    <= 1'b0;
            chip_valid <= 1'b0;
            chip_idx   <= 10'd0;
            epoch      <= 1'b0;
            prn_err    <= 1'b0;
`ifdef GPS_CA_EPOCH_CNT_EN
            epoch_cnt  <= 5'd0;
            bit_edge   <= 1'b0;
`endif
        end else begin
            chip_valid <= 1'b0;
            epoch      <= 1'b0;
            prn_err    <= start && !stop && !w_sv_ok;
`ifdef GPS_CA_EPOCH_CNT_EN
            bit_edge   <= 1'b0;
`endif
            if (w_load) begin
                // (Re)start: present chip 0 next cycle, LFSRs already one step on.
                r_state    <= S_RUN;
                r_tap_a    <= w_taps[7:4];
                r_tap_b    <= w_taps[3:0];
                r_g1       <= c_STEP1;
                r_g2       <= c_STEP1;
                r_div      <= '0;
                ca_code    <= 1'b1;
                chip_valid <= 1'b1;
                chip_idx   <= 10'd0;
                epoch      <= 1'b1;
`ifdef GPS_CA_EPOCH_CNT_EN
                epoch_cnt  <= 5'd0;
                bit_edge   <= 1'b1;
`endif
            end else if (r_state == S_RUN) begin
                if (stop) begin
                    r_state <= S_IDLE;
                end else if (r_div == c_DIV_LAST) begin
                    r_div      <= '0;
                    chip_valid <= 1'b1;
                    if (chip_idx == c_LAST_CHIP) begin
                        // Period boundary: reload rather than trust free-running alignment.
                        chip_idx <= 10'd0;
                        ca_code  <= 1'b1;
                        r_g1     <= c_STEP1;
                        r_g2     <= c_STEP1;
                        epoch    <= 1'b1;
`ifdef GPS_CA_EPOCH_CNT_EN
                        epoch_cnt <= (epoch_cnt == 5'd19) ? 5'd0 : epoch_cnt + 5'd1;
                        bit_edge  <= (epoch_cnt == 5'd19);
`endif
                    end else begin
                        chip_idx <= chip_idx + 10'd1;
                        ca_code  <= w_chip;
                        r_g1     <= w_g1_next;
                        r_g2     <= w_g2_next;
                    end
                end else begin
                    r_div <= r_div + c_DIV_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
